// File: rtl/uart_transmitter.sv
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Serialises one data word into a UART frame paced by the 16x baud
//            tick. Optional even-parity bit enabled by macro UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_transmitter #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int OS_TICKS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tx_start,
    input  logic                 i_bd_tick,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int c_MAX_TICKS = (SB_TICKS > OS_TICKS) ? SB_TICKS : OS_TICKS;
    localparam int c_TICK_W    = $clog2(c_MAX_TICKS + 1);
    localparam int c_BIT_W     = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_OS_LAST  = c_TICK_W'(OS_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_SB_LAST  = c_TICK_W'(SB_TICKS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t                r_state;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_tx;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic [DATA_BITS-1:0]  w_shift_next;
    assign w_shift_next = r_shift >> 1;

    // Done is decoded from the final stop tick so it coincides with the last
    // STOP cycle; a new request is therefore only taken the cycle after.
    assign o_tx_done = (r_state == ST_STOP) && i_bd_tick && (r_tick_cnt == c_SB_LAST);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_tx      = r_tx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_tick_cnt <= '0;
                    if (i_tx_start) begin
                        r_shift <= i_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^i_data;
`endif
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_bd_tick) begin
                        if (r_tick_cnt == c_OS_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_tx       <= r_shift[0];
                            r_state    <= ST_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_bd_tick) begin
                        if (r_tick_cnt == c_OS_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= w_shift_next;
                            if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
`else
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_tx      <= w_shift_next[0];
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (i_bd_tick) begin
                        if (r_tick_cnt == c_OS_LAST) begin
                            r_tick_cnt <= '0;
                            r_tx       <= 1'b1;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (i_bd_tick) begin
                        if (r_tick_cnt == c_SB_LAST) begin
                            r_tick_cnt <= '0;
                            r_tx       <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Directed self-checking bench for uart_transmitter (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tx_start = 1'b0;
    logic       i_bd_tick = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx;
    logic       o_busy;
    logic       o_tx_done;

    int n_checks = 0;
    int n_fail = 0;
    int done_count = 0;

    uart_transmitter #(
        .DATA_BITS (8),
        .SB_TICKS  (16),
        .OS_TICKS  (16)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tx_start (i_tx_start),
        .i_bd_tick  (i_bd_tick),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_tx_done  (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    // Mid-cycle count of done pulses
    always @(negedge i_clk) begin
        if (o_tx_done === 1'b1) done_count++;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One baud tick: three quiet cycles then a single-cycle tick
    task automatic tick();
        i_bd_tick = 1'b0;
        repeat (3) step();
        i_bd_tick = 1'b1;
        step();
        i_bd_tick = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] d);
        i_data     = d;
        i_tx_start = 1'b1;
        step();
        i_tx_start = 1'b0;
        check("start_tx_low", o_tx, 1'b0);
        check("start_busy", o_busy, 1'b1);
    endtask

    // mode 0: plain frame, 1: poke data/start in data bit 3, 2: reset in data bit 4
    task automatic frame_body(input logic [7:0] d, input int mode);
        logic exp_bits [0:9];
        int   nslots;
        int   d0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        exp_bits[9] = 1'b1;
        nslots = 9;
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^d;
        nslots = 10;
`endif
        d0 = done_count;
        for (int s = 0; s < nslots; s++) begin
            for (int t = 0; t < 16; t++) begin
                check($sformatf("frame_bit slot%0d tick%0d", s, t), o_tx, exp_bits[s]);
                if (t == 0) check("frame_busy", o_busy, 1'b1);
                if (mode == 1 && s == 4 && t == 8) begin
                    i_data     = 8'hFF;
                    i_tx_start = 1'b1;
                    step();
                    i_tx_start = 1'b0;
                end
                if (mode == 2 && s == 5 && t == 5) begin
                    i_reset = 1'b1;
                    step();
                    i_reset = 1'b0;
                    check("reset_tx_high", o_tx, 1'b1);
                    check("reset_busy_low", o_busy, 1'b0);
                    check("reset_no_done", done_count, d0);
                    return;
                end
                tick();
            end
        end
        for (int t = 0; t < 16; t++) begin
            check($sformatf("stop tick%0d", t), o_tx, 1'b1);
            if (t == 15) check("done_not_early", done_count, d0);
            tick();
        end
        check("done_once", done_count, d0 + 1);
        check("end_tx_high", o_tx, 1'b1);
        check("end_busy_low", o_busy, 1'b0);
    endtask

    initial begin
        // Reset state
        i_reset = 1'b1;
        repeat (3) step();
        check("rst_tx", o_tx, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_tx_done, 1'b0);
        i_reset = 1'b0;
        step();

        // Ticks in IDLE do nothing
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_tick_tx", o_tx, 1'b1);
            check("idle_tick_busy", o_busy, 1'b0);
        end
        check("idle_no_done", done_count, 0);

        // Basic frame 0xA5
        start_frame(8'hA5);
        frame_body(8'hA5, 0);

        // 0x3C with data change and ignored start mid-frame
        start_frame(8'h3C);
        frame_body(8'h3C, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_second_tx", o_tx, 1'b1);
            check("no_second_busy", o_busy, 1'b0);
        end

        // Back-to-back with start held high: 0x00 then 0xFF
        i_data     = 8'h00;
        i_tx_start = 1'b1;
        step();
        check("b2b_first_low", o_tx, 1'b0);
        i_data = 8'hFF;
        frame_body(8'h00, 0);
        step();
        check("b2b_gap_one_cycle", o_tx, 1'b0);
        check("b2b_busy", o_busy, 1'b1);
        frame_body(8'hFF, 0);
        i_tx_start = 1'b0;
        step();
        check("b2b_end_tx", o_tx, 1'b1);
        check("b2b_end_busy", o_busy, 1'b0);

        // Reset during data bit 4 of 0x81, then a clean 0x81 frame
        start_frame(8'h81);
        frame_body(8'h81, 2);
        tick();
        check("post_reset_idle", o_tx, 1'b1);
        start_frame(8'h81);
        frame_body(8'h81, 0);

`ifdef UART_TX_PARITY_EN
        start_frame(8'hA5);
        frame_body(8'hA5, 0);
        start_frame(8'h07);
        frame_body(8'h07, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
